// File: rtl/frame_demapper.sv
// Receive-side frame demapper: hunts for the FAS, tracks row/col position and forwards payload bytes.
// Define FAS_ERR_CNT_EN to add o_fas_err_cnt, a saturating count of failed FAS checks since reset.
module frame_demapper #(
    parameter int NUM_ROWS   = 4,
    parameter int ROW_LEN    = 1041,
    parameter int OH_COLS    = 16,
    parameter int LOF_THRESH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    output logic [7:0]  o_pyld_data,
    output logic        o_pyld_data_valid,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_frame_start,
    output logic        o_frame_lock,
`ifdef FAS_ERR_CNT_EN
    output logic [15:0] o_fas_err_cnt,
`endif
    output logic [1:0]  o_dbg_state
);

    localparam logic [47:0] FAS          = 48'hF6F6F6282828;
    localparam logic [10:0] FAS_LAST_COL = 11'd5;
    localparam logic [10:0] LAST_COL     = 11'(ROW_LEN - 1);
    localparam logic [10:0] PYLD_FIRST   = 11'(OH_COLS);
    localparam logic [10:0] PYLD_LAST    = 11'(ROW_LEN - 2);
    localparam logic [1:0]  LAST_ROW     = 2'(NUM_ROWS - 1);
    localparam int          BW           = $clog2(LOF_THRESH + 1);
    localparam logic [BW-1:0] LOF        = BW'(LOF_THRESH);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        LOCK    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] bad_cnt;
    logic [BW-1:0] bad_nxt;
    logic [BW-1:0] bad_inc;
    logic [47:0]   fas_sr;
    logic [1:0]    row_cnt;
    logic [10:0]   col_cnt;
    logic          fas_match;
    logic          check_pt;
    logic          check_fail;
    logic          pos_load;
    logic          pyld_take;

    // The current valid byte completes the pattern as the final 0x28.
    assign fas_match  = ({fas_sr[39:0], i_frame_data} == FAS);
    assign check_pt   = i_frame_data_valid && (state != HUNT) &&
                        (row_cnt == 2'd0) && (col_cnt == FAS_LAST_COL);
    assign check_fail = check_pt && !fas_match;
    assign bad_inc    = (bad_cnt == LOF) ? LOF : bad_cnt + 1'b1;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= HUNT;
            bad_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bad_cnt <= bad_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        bad_nxt   = bad_cnt;
        case (state)
            HUNT: begin
                if (i_frame_data_valid && fas_match)
                    state_nxt = PRESYNC;
            end
            PRESYNC: begin
                if (check_pt) begin
                    if (check_fail) begin
                        state_nxt = HUNT;
                    end else begin
                        state_nxt = LOCK;
                        bad_nxt   = '0;
                    end
                end
            end
            LOCK: begin
                if (check_pt) begin
                    if (check_fail) begin
                        bad_nxt = bad_inc;
                        if (bad_inc == LOF)
                            state_nxt = HUNT;
                    end else begin
                        bad_nxt = '0;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Output decode: position reload in HUNT and payload selection in LOCK.
    always_comb begin
        pos_load  = 1'b0;
        pyld_take = 1'b0;
        if (i_frame_data_valid) begin
            pos_load  = (state == HUNT) && fas_match;
            pyld_take = (state == LOCK) && (col_cnt >= PYLD_FIRST) && (col_cnt <= PYLD_LAST);
        end
    end

    // FAS history is kept across a lock loss so a pattern straddling the exit is still found.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            fas_sr <= '0;
        else if (i_frame_data_valid)
            fas_sr <= {fas_sr[39:0], i_frame_data};
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (i_frame_data_valid) begin
            if (pos_load) begin
                row_cnt <= '0;
                col_cnt <= FAS_LAST_COL + 11'd1;
            end else if (col_cnt == LAST_COL) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == LAST_ROW) ? 2'd0 : row_cnt + 2'd1;
            end else begin
                col_cnt <= col_cnt + 11'd1;
            end
        end
    end

    // Payload registers hold their last value when no byte is forwarded.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_pyld_data       <= '0;
            o_pyld_data_valid <= 1'b0;
            o_row_cnt         <= '0;
            o_col_cnt         <= '0;
            o_frame_start     <= 1'b0;
            o_frame_lock      <= 1'b0;
        end else begin
            o_pyld_data_valid <= pyld_take;
            o_frame_start     <= pyld_take && (row_cnt == 2'd0) && (col_cnt == PYLD_FIRST);
            o_frame_lock      <= (state == LOCK);
            if (pyld_take) begin
                o_pyld_data <= i_frame_data;
                o_row_cnt   <= row_cnt;
                o_col_cnt   <= col_cnt;
            end
        end
    end

`ifdef FAS_ERR_CNT_EN
    logic [15:0] fas_err_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            fas_err_cnt <= '0;
        else if (check_fail && (fas_err_cnt != 16'hFFFF))
            fas_err_cnt <= fas_err_cnt + 16'd1;
    end

    assign o_fas_err_cnt = fas_err_cnt;
`endif

    assign o_dbg_state = state;

endmodule

// File: tb/tb_frame_demapper.sv
// Bench for frame_demapper: table of stream segments plus hand-written reset and false-FAS sequences.
// Payload bytes are scoreboarded with their issue cycle to pin the one-cycle latency.
`timescale 1ns/1ps
module tb_frame_demapper;

    localparam int W    = 54;   // {stamp[31:0], fs, row[1:0], col[10:0], data[7:0]}
    localparam int NSEG = 5;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  i_frame_data = 8'h00;
    logic        i_frame_data_valid = 1'b0;
    logic [7:0]  o_pyld_data;
    logic        o_pyld_data_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_frame_start;
    logic        o_frame_lock;
    logic [1:0]  o_dbg_state;
`ifdef FAS_ERR_CNT_EN
    logic [15:0] o_fas_err_cnt;
`endif

    frame_demapper dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_frame_data       (i_frame_data),
        .i_frame_data_valid (i_frame_data_valid),
        .o_pyld_data        (o_pyld_data),
        .o_pyld_data_valid  (o_pyld_data_valid),
        .o_row_cnt          (o_row_cnt),
        .o_col_cnt          (o_col_cnt),
        .o_frame_start      (o_frame_start),
        .o_frame_lock       (o_frame_lock),
`ifdef FAS_ERR_CNT_EN
        .o_fas_err_cnt      (o_fas_err_cnt),
`endif
        .o_dbg_state        (o_dbg_state)
    );

    // Clock / reset block.
    always #5 i_clk = ~i_clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pyld_seq = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    typedef struct {
        logic       do_reset;
        logic       junk;
        int         n_frames;
        int         gap_pct;
        logic [7:0] bad_mask;
        logic [7:0] pyld_mask;
        logic       lock_end;
        logic [1:0] state_end;
        int         err_end;
    } vec_t;

    vec_t vecs[NSEG];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pops one entry per forwarded byte, flags missing and unexpected bytes.
    always @(posedge i_clk) begin
        #1;
        if (o_pyld_data_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pyld_unexpected: got r%0d c%0d d%02h, expected no byte",
                         o_row_cnt, o_col_cnt, o_pyld_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("pyld_fields", {10'd0, o_frame_start, o_row_cnt, o_col_cnt, o_pyld_data},
                      {10'd0, mon_e[21:0]});
                check("pyld_latency", 32'(cyc - 1), mon_e[53:22]);
            end
        end else begin
            check("fs_idle", {31'd0, o_frame_start}, 32'd0);
            if (exp_q.size() > 0 && int'(exp_q[0][53:22]) < cyc) begin
                mon_e = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL pyld_missing: got no byte, expected r%0d c%0d d%02h",
                         mon_e[20:19], mon_e[18:8], mon_e[7:0]);
            end
        end
    end

    // Driver tasks.
    task automatic drive_byte(input logic [7:0] b, input logic exp_out, input logic fs,
                              input logic [1:0] r, input logic [10:0] c, input int gap_pct);
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            @(negedge i_clk);
            i_frame_data       = 8'($urandom_range(255));
            i_frame_data_valid = 1'b0;
        end
        @(negedge i_clk);
        i_frame_data       = b;
        i_frame_data_valid = 1'b1;
        if (exp_out)
            exp_q.push_back({32'(cyc), fs, r, c, b});
    endtask

    task automatic go_idle(input int n);
        @(negedge i_clk);
        i_frame_data_valid = 1'b0;
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    function automatic logic [7:0] fas_byte(input int c);
        return (c < 3) ? 8'hF6 : 8'h28;
    endfunction

    task automatic send_frame(input logic bad, input logic exp_pyld, input int gap_pct,
                              input int n_bytes);
        int k;
        logic [7:0] b;
        logic is_p;
        k = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 1041; c++) begin
                if (k >= n_bytes) return;
                is_p = 1'b0;
                if (r == 0 && c < 6) begin
                    b = (bad && c == 4) ? 8'h29 : fas_byte(c);
                end else if (c >= 16 && c <= 1039) begin
                    b = pyld_seq[7:0];
                    pyld_seq++;
                    is_p = 1'b1;
                end else begin
                    b = 8'h00;
                end
                drive_byte(b, is_p && exp_pyld, (r == 0 && c == 16), 2'(r), 11'(c), gap_pct);
                k++;
            end
        end
    endtask

    // Pre-frame junk carrying an FAS look-alike at offsets 50..55.
    task automatic send_junk();
        logic [7:0] b;
        for (int i = 0; i < 200; i++) begin
            if (i >= 50 && i <= 55) b = fas_byte(i - 50);
            else b = 8'h5A;
            drive_byte(b, 1'b0, 1'b0, 2'd0, 11'd0, 0);
        end
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, o_pyld_data_valid}, 32'd0);
        check({tag, "_data"},  {24'd0, o_pyld_data}, 32'd0);
        check({tag, "_row"},   {30'd0, o_row_cnt}, 32'd0);
        check({tag, "_col"},   {21'd0, o_col_cnt}, 32'd0);
        check({tag, "_fs"},    {31'd0, o_frame_start}, 32'd0);
        check({tag, "_lock"},  {31'd0, o_frame_lock}, 32'd0);
        check({tag, "_state"}, {30'd0, o_dbg_state}, 32'd0);
`ifdef FAS_ERR_CNT_EN
        check({tag, "_errcnt"}, {16'd0, o_fas_err_cnt}, 32'd0);
`endif
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst              = 1'b0;
        i_frame_data_valid = 1'b0;
        i_frame_data       = 8'h00;
        @(negedge i_clk);
        check_rst_outputs("rst");
        check("rst_q_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        i_rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // do_reset, junk, frames, gap%, bad FAS mask, payload-frame mask, lock, state, err count
        vecs[0] = '{1'b1, 1'b0, 3, 0,  8'b0000_0000, 8'b0000_0110, 1'b1, 2'd2, 0};
        vecs[1] = '{1'b0, 1'b0, 1, 30, 8'b0000_0000, 8'b0000_0001, 1'b1, 2'd2, 0};
        vecs[2] = '{1'b0, 1'b0, 4, 0,  8'b0000_0111, 8'b0000_1111, 1'b1, 2'd2, 3};
        vecs[3] = '{1'b0, 1'b0, 4, 0,  8'b0000_1111, 8'b0000_0111, 1'b0, 2'd0, 7};
        vecs[4] = '{1'b1, 1'b1, 5, 0,  8'b0000_0100, 8'b0001_0000, 1'b1, 2'd2, 2};

        repeat (3) @(negedge i_clk);
        check_rst_outputs("init");
        i_rst = 1'b1;

        for (int s = 0; s < NSEG; s++) begin
            if (vecs[s].do_reset) apply_reset();
            if (vecs[s].junk) begin
                send_junk();
                @(posedge i_clk);
                #2;
                check("junk_false_presync", {30'd0, o_dbg_state}, 32'd1);
                check("junk_lock", {31'd0, o_frame_lock}, 32'd0);
            end
            for (int f = 0; f < vecs[s].n_frames; f++)
                send_frame(vecs[s].bad_mask[f], vecs[s].pyld_mask[f], vecs[s].gap_pct, 4164);
            go_idle(3);
            check($sformatf("seg%0d_lock", s), {31'd0, o_frame_lock}, {31'd0, vecs[s].lock_end});
            check($sformatf("seg%0d_state", s), {30'd0, o_dbg_state}, {30'd0, vecs[s].state_end});
            check($sformatf("seg%0d_q_empty", s), exp_q.size(), 32'd0);
`ifdef FAS_ERR_CNT_EN
            check($sformatf("seg%0d_errcnt", s), {16'd0, o_fas_err_cnt}, 32'(vecs[s].err_end));
`endif
        end

        // Reset in the middle of a locked frame, then a single good FAS must not relock.
        send_frame(1'b0, 1'b1, 0, 100);
        @(posedge i_clk);
        #2;
        check("pre_rst_valid", {31'd0, o_pyld_data_valid}, 32'd1);
        check("pre_rst_lock", {31'd0, o_frame_lock}, 32'd1);
        i_rst              = 1'b0;
        i_frame_data_valid = 1'b0;
        #1;
        check_rst_outputs("midrst");
        @(negedge i_clk);
        i_rst = 1'b1;
        send_frame(1'b0, 1'b0, 0, 4164);
        go_idle(3);
        check("relock_one_fas_lock", {31'd0, o_frame_lock}, 32'd0);
        check("relock_one_fas_state", {30'd0, o_dbg_state}, 32'd1);
        check("relock_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
